// File: rtl/sda_reg_pkg.sv
// Shared codes, FSM encodings and payload types for the AXI4-Lite to
// simple-register bridge.
package sda_reg_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = 4;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRegWrite  = 3'd1,
    StRegRead   = 3'd2,
    StWriteResp = 3'd3,
    StReadResp  = 3'd4
  } state_e;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
  } reg_wr_t;

endpackage

// File: rtl/sda_reg_timeout_counter.sv
// Counts cycles of an outstanding register request and flags the cycle in
// which the request has been waiting for Cycles cycles without completion.
module sda_reg_timeout_counter #(
  parameter int unsigned Cycles = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Expire in the last waiting cycle so the request drops on the next edge.
  always_comb begin
    expired_c = en && (cnt_q == CntW'(Cycles - 1));
    cnt_d     = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired_c) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sda_axi_reg_bridge.sv
// AXI4-Lite slave to simple-register (req/ack) bridge, one transaction in
// flight. Optional request timeout: define SDA_AXI_REG_BRIDGE_TIMEOUT_EN.
module sda_axi_reg_bridge
  import sda_reg_pkg::*;
#(
  parameter int unsigned RegAddrWidth  = 7,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    sAxiAwValid,
  output logic                    sAxiAwReady,
  input  logic [RegAddrWidth-1:0] sAxiAwAddr,
  input  logic                    sAxiWValid,
  output logic                    sAxiWReady,
  input  logic [31:0]             sAxiWData,
  input  logic [3:0]              sAxiWStrb,
  output logic                    sAxiBValid,
  input  logic                    sAxiBReady,
  output logic [1:0]              sAxiBResp,
  input  logic                    sAxiArValid,
  output logic                    sAxiArReady,
  input  logic [RegAddrWidth-1:0] sAxiArAddr,
  output logic                    sAxiRValid,
  input  logic                    sAxiRReady,
  output logic [31:0]             sAxiRData,
  output logic [1:0]              sAxiRResp,
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  output logic [3:0]              regWStrb,
  input  logic [31:0]             regRData
);

  state_e                  state_q, state_d;
  logic                    last_wr_q, last_wr_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  reg_wr_t                 wr_q, wr_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [DataW-1:0]        rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic accept_wr_c;
  logic accept_rd_c;
  logic timeout_c;
  logic wr_pend_c;
  logic rd_pend_c;

`ifdef SDA_AXI_REG_BRIDGE_TIMEOUT_EN
  sda_reg_timeout_counter #(
    .Cycles(TimeoutCycles)
  ) u_timeout (
    .clk       (clk),
    .srst      (srst),
    .clr       (accept_wr_c | accept_rd_c),
    .en        (req_q),
    .expired_c (timeout_c)
  );
`else
  localparam int unsigned unused_timeout_cycles = TimeoutCycles;
  assign timeout_c = 1'b0;
`endif

  // Next-state, request capture and response generation.
  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    accept_wr_c = 1'b0;
    accept_rd_c = 1'b0;
    wr_pend_c   = sAxiAwValid && sAxiWValid;
    rd_pend_c   = sAxiArValid;

    case (state_q)
      StIdle: begin
        // Alternate on contention; last_wr_q resets low so writes win first.
        if (!srst) begin
          if (wr_pend_c && (!rd_pend_c || !last_wr_q)) begin
            accept_wr_c = 1'b1;
          end else if (rd_pend_c) begin
            accept_rd_c = 1'b1;
          end
        end
        if (accept_wr_c) begin
          state_d   = StRegWrite;
          last_wr_d = 1'b1;
          req_d     = 1'b1;
          we_d      = 1'b1;
          addr_d    = sAxiAwAddr;
          wr_d      = '{data: sAxiWData, strb: sAxiWStrb};
        end else if (accept_rd_c) begin
          state_d   = StRegRead;
          last_wr_d = 1'b0;
          req_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = sAxiArAddr;
          wr_d      = '0;
        end
      end
      StRegWrite: begin
        if (regAck || timeout_c) begin
          state_d  = StWriteResp;
          req_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = '0;
          wr_d     = '0;
          bvalid_d = 1'b1;
          bresp_d  = regAck ? RespOkay : RespSlvErr;
        end
      end
      StRegRead: begin
        if (regAck || timeout_c) begin
          state_d  = StReadResp;
          req_d    = 1'b0;
          addr_d   = '0;
          rvalid_d = 1'b1;
          rdata_d  = regAck ? regRData : '0;
          rresp_d  = regAck ? RespOkay : RespSlvErr;
        end
      end
      StWriteResp: begin
        if (sAxiBReady) begin
          state_d  = StIdle;
          bvalid_d = 1'b0;
          bresp_d  = RespOkay;
        end
      end
      StReadResp: begin
        if (sAxiRReady) begin
          state_d  = StIdle;
          rvalid_d = 1'b0;
          rdata_d  = '0;
          rresp_d  = RespOkay;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wr_q      <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign sAxiAwReady = accept_wr_c;
  assign sAxiWReady  = accept_wr_c;
  assign sAxiArReady = accept_rd_c;
  assign sAxiBValid  = bvalid_q;
  assign sAxiBResp   = bresp_q;
  assign sAxiRValid  = rvalid_q;
  assign sAxiRData   = rdata_q;
  assign sAxiRResp   = rresp_q;
  assign regReq      = req_q;
  assign regWriteEn  = we_q;
  assign regAddr     = addr_q;
  assign regWData    = wr_q.data;
  assign regWStrb    = wr_q.strb;

endmodule
